// File: rtl/snitch_mem_pkg.sv
// Shared types and AMO arithmetic for the snitch data-memory responder.
// AMO math runs on AmoWidth bits; callers sign-extend narrower words so MAX/MIN stay signed.
package snitch_mem_pkg;

   localparam int unsigned AmoWidth = 128;

   typedef enum logic [3:0] {
      AmoNone = 4'd0,
      AmoSwap = 4'd1,
      AmoAdd  = 4'd2,
      AmoAnd  = 4'd3,
      AmoOr   = 4'd4,
      AmoXor  = 4'd5,
      AmoMax  = 4'd6,
      AmoMin  = 4'd7
   } amo_op_e;

   typedef struct packed {
      logic [AmoWidth-1:0] data;
      logic                error;
   } resp_t;

   function automatic logic [AmoWidth-1:0] amo_apply(input amo_op_e             op,
                                                     input logic [AmoWidth-1:0] old_val,
                                                     input logic [AmoWidth-1:0] operand);
      logic [AmoWidth-1:0] res;
      res = old_val;
      case (op)
         AmoSwap: res = operand;
         AmoAdd:  res = old_val + operand;
         AmoAnd:  res = old_val & operand;
         AmoOr:   res = old_val | operand;
         AmoXor:  res = old_val ^ operand;
         AmoMax:  res = ($signed(old_val) > $signed(operand)) ? old_val : operand;
         AmoMin:  res = ($signed(old_val) < $signed(operand)) ? old_val : operand;
         default: res = old_val;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/snitch_resp_fifo.sv
// In-order response FIFO; storage is not reset, only the pointers and count are.
module snitch_resp_fifo
   import snitch_mem_pkg::*;
#(
   parameter int unsigned Depth = 4,
   parameter type         T     = snitch_mem_pkg::resp_t
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic push_i,
   input  T     data_i,
   input  logic pop_i,
   output T     data_o,
   output logic full_o,
   output logic empty_o
);

   localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntWidth = $clog2(Depth + 1);

   T                    mem_q [Depth];
   logic [PtrWidth-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CntWidth-1:0] cnt_q, cnt_d;
   logic                do_push, do_pop;

   assign full_o  = (cnt_q == CntWidth'(Depth));
   assign empty_o = (cnt_q == '0);
   assign data_o  = mem_q[rptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (do_push) wptr_d = (wptr_q == PtrWidth'(Depth - 1)) ? '0 : wptr_q + PtrWidth'(1);
      if (do_pop)  rptr_d = (rptr_q == PtrWidth'(Depth - 1)) ? '0 : rptr_q + PtrWidth'(1);
      unique case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CntWidth'(1);
         2'b01:   cnt_d = cnt_q - CntWidth'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q] <= data_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/snitch_data_mem.sv
// Data-memory responder for the snitch q/p data port: word storage with strobes, AMOs,
// error responses, fixed-latency delay line and credit-bounded in-order response queue.
module snitch_data_mem
   import snitch_mem_pkg::*;
#(
   parameter int unsigned          AddrWidth      = 32,
   parameter int unsigned          DataWidth      = 64,
   parameter int unsigned          NumWords       = 1024,
   parameter logic [AddrWidth-1:0] BaseAddr       = 32'hCAFE_0000,
   parameter int unsigned          Latency        = 1,
   parameter int unsigned          MaxOutstanding = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [AddrWidth-1:0]   data_qaddr_i,
   input  logic                   data_qwrite_i,
   input  logic [3:0]             data_qamo_i,
   input  logic [DataWidth-1:0]   data_qdata_i,
   input  logic [DataWidth/8-1:0] data_qstrb_i,
   input  logic                   data_qvalid_i,
   output logic                   data_qready_o,
   output logic [DataWidth-1:0]   data_pdata_o,
   output logic                   data_perror_o,
   output logic                   data_pvalid_o,
   input  logic                   data_pready_i
);

   localparam int unsigned StrbWidth = DataWidth / 8;
   localparam int unsigned OffBits   = $clog2(StrbWidth);
   localparam int unsigned IdxWidth  = (NumWords > 1) ? $clog2(NumWords) : 1;
   localparam int unsigned CntWidth  = $clog2(MaxOutstanding + 1);

   typedef struct packed {
      logic [DataWidth-1:0] data;
      logic                 error;
   } mem_resp_t;

   logic [DataWidth-1:0] mem_q [NumWords];
   logic [CntWidth-1:0]  credit_q, credit_d;
   logic                 accept, p_hs;
   logic [AddrWidth-1:0] word_off;
   logic [IdxWidth-1:0]  idx;
   logic                 in_range, req_err, mem_we;
   amo_op_e              amo_op;
   logic [DataWidth-1:0] old_word, amo_res, op_word, new_word;
   mem_resp_t            req_resp, dl_out, fifo_data, resp_out;
   mem_resp_t            dl_q [Latency];
   logic                 dl_valid_q [Latency];
   logic                 dl_out_valid, fifo_push, fifo_pop, fifo_full, fifo_empty;

   assign data_qready_o = (credit_q < CntWidth'(MaxOutstanding));
   assign accept        = data_qvalid_i && data_qready_o;
   assign p_hs          = data_pvalid_o && data_pready_i;

   // Modular subtraction: addresses below BaseAddr wrap high and are caught by the >= test.
   assign word_off = (data_qaddr_i - BaseAddr) >> OffBits;
   assign in_range = (data_qaddr_i >= BaseAddr) && (word_off < AddrWidth'(NumWords));
   assign idx      = IdxWidth'(word_off);
   assign amo_op   = amo_op_e'(data_qamo_i);
   assign req_err  = !in_range || (data_qwrite_i && (amo_op != AmoNone)) ||
                     (!data_qwrite_i && (data_qamo_i > 4'd7));
   assign mem_we   = accept && !req_err && (data_qwrite_i || (amo_op != AmoNone));
   assign old_word = mem_q[idx];

   always_comb begin
      amo_res = DataWidth'(amo_apply(amo_op, AmoWidth'($signed(old_word)),
                                     AmoWidth'($signed(data_qdata_i))));
      op_word = data_qwrite_i ? data_qdata_i : amo_res;
      for (int b = 0; b < StrbWidth; b++) begin
         new_word[b*8 +: 8] = data_qstrb_i[b] ? op_word[b*8 +: 8] : old_word[b*8 +: 8];
      end
      req_resp.error = req_err;
      req_resp.data  = (req_err || data_qwrite_i) ? '0 : old_word;
   end

   always_ff @(posedge clk_i) begin
      if (mem_we) mem_q[idx] <= new_word;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < Latency; i++) begin
            dl_valid_q[i] <= 1'b0;
            dl_q[i]       <= '0;
         end
      end else begin
         dl_valid_q[0] <= accept;
         dl_q[0]       <= req_resp;
         for (int i = 1; i < Latency; i++) begin
            dl_valid_q[i] <= dl_valid_q[i-1];
            dl_q[i]       <= dl_q[i-1];
         end
      end
   end

   assign dl_out_valid = dl_valid_q[Latency-1];
   assign dl_out       = dl_q[Latency-1];

   // The delay-line head bypasses an empty FIFO; it is queued only if not taken this cycle.
   assign fifo_push = dl_out_valid && !(fifo_empty && data_pready_i);
   assign fifo_pop  = !fifo_empty && data_pready_i;

   snitch_resp_fifo #(
      .Depth (MaxOutstanding),
      .T     (mem_resp_t)
   ) u_resp_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (fifo_push),
      .data_i  (dl_out),
      .pop_i   (fifo_pop),
      .data_o  (fifo_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign resp_out      = fifo_empty ? dl_out : fifo_data;
   assign data_pvalid_o = !fifo_empty || dl_out_valid;
   assign data_pdata_o  = data_pvalid_o ? resp_out.data : '0;
   assign data_perror_o = data_pvalid_o && resp_out.error;

   always_comb begin
      credit_d = credit_q;
      unique case ({accept, p_hs})
         2'b10:   credit_d = credit_q + CntWidth'(1);
         2'b01:   credit_d = credit_q - CntWidth'(1);
         default: credit_d = credit_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) credit_q <= '0;
      else         credit_q <= credit_d;
   end

   a_q_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (data_qvalid_i && !data_qready_o) |=> $stable({data_qaddr_i, data_qwrite_i, data_qamo_i,
                                                      data_qdata_i, data_qstrb_i}));
   a_pvalid_credit: assert property (@(posedge clk_i) disable iff (!rst_ni)
      data_pvalid_o |-> (credit_q != '0));
   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_snitch_data_mem.sv
// Directed bench: one instance at Latency=1/MaxOutstanding=4, one at Latency=3/MaxOutstanding=2.
module tb_snitch_data_mem;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] qaddr, qaddr2;
   logic        qwrite, qwrite2;
   logic [3:0]  qamo, qamo2;
   logic [63:0] qdata, qdata2, pdata, pdata2;
   logic [7:0]  qstrb, qstrb2;
   logic        qvalid, qvalid2, qready, qready2;
   logic        perror, perror2, pvalid, pvalid2, pready, pready2;

   snitch_data_mem u_dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .data_qaddr_i  (qaddr),
      .data_qwrite_i (qwrite),
      .data_qamo_i   (qamo),
      .data_qdata_i  (qdata),
      .data_qstrb_i  (qstrb),
      .data_qvalid_i (qvalid),
      .data_qready_o (qready),
      .data_pdata_o  (pdata),
      .data_perror_o (perror),
      .data_pvalid_o (pvalid),
      .data_pready_i (pready)
   );

   snitch_data_mem #(
      .Latency        (3),
      .MaxOutstanding (2)
   ) u_dut_l3 (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .data_qaddr_i  (qaddr2),
      .data_qwrite_i (qwrite2),
      .data_qamo_i   (qamo2),
      .data_qdata_i  (qdata2),
      .data_qstrb_i  (qstrb2),
      .data_qvalid_i (qvalid2),
      .data_qready_o (qready2),
      .data_pdata_o  (pdata2),
      .data_perror_o (perror2),
      .data_pvalid_o (pvalid2),
      .data_pready_i (pready2)
   );

   int n_chk = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   // One request on the Latency=1 instance; returns the response and cycles to pvalid.
   task automatic req(input logic [31:0] addr, input logic wr, input logic [3:0] amo,
                      input logic [63:0] wdata, input logic [7:0] strb,
                      output logic [63:0] rdata, output logic rerr, output int lat);
      int w;
      qaddr  = addr;
      qwrite = wr;
      qamo   = amo;
      qdata  = wdata;
      qstrb  = strb;
      qvalid = 1'b1;
      w = 0;
      while (!qready && w < 20) begin
         @(posedge clk); #1;
         w++;
      end
      @(posedge clk); #1;
      qvalid = 1'b0;
      lat = 1;
      while (!pvalid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      rdata = pdata;
      rerr  = perror;
      @(posedge clk); #1;
   endtask

   logic [31:0] e_addr [4] = '{32'hCAFE_2000, 32'h0000_0000, 32'hCAFE_0010, 32'hCAFE_0010};
   logic        e_wr   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
   logic [3:0]  e_amo  [4] = '{4'd0, 4'd0, 4'd1, 4'd12};

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] rd;
      logic        re;
      int          lat;
      int          acc, got_n, bad_ord, stalls, k;
      logic [63:0] r [2];

      {qaddr, qwrite, qamo, qdata, qstrb, qvalid} = '0;
      {qaddr2, qwrite2, qamo2, qdata2, qstrb2, qvalid2} = '0;
      pready  = 1'b1;
      pready2 = 1'b1;
      #2;
      check("rst_pvalid", 64'(pvalid), 64'd0);
      check("rst_pdata", pdata, 64'd0);
      check("rst_perror", 64'(perror), 64'd0);
      check("rst_qready", 64'(qready), 64'd1);
      check("rst_qready_l3", 64'(qready2), 64'd1);
      #20 rst_n = 1'b1;
      @(posedge clk); #1;

      // Store then load, with a partial-strobe overlay.
      req(32'hCAFE_1000, 1'b1, 4'd0, 64'h0, 8'hFF, rd, re, lat);
      req(32'hCAFE_1000, 1'b1, 4'd0, 64'h1, 8'h0F, rd, re, lat);
      check("st_data", rd, 64'd0);
      check("st_err", 64'(re), 64'd0);
      req(32'hCAFE_1000, 1'b0, 4'd0, 64'h0, 8'hFF, rd, re, lat);
      check("ld_data", rd, 64'h1);
      check("ld_err", 64'(re), 64'd0);
      check("ld_lat", 64'(lat), 64'd1);
      req(32'hCAFE_1000, 1'b1, 4'd0, 64'hAAAA_BBBB_CCCC_DDDD, 8'hF0, rd, re, lat);
      req(32'hCAFE_1000, 1'b0, 4'd0, 64'h0, 8'hFF, rd, re, lat);
      check("strb_hi", rd, 64'hAAAA_BBBB_0000_0001);

      // AMOs on word 2.
      req(32'hCAFE_0010, 1'b1, 4'd0, 64'd5, 8'hFF, rd, re, lat);
      req(32'hCAFE_0010, 1'b0, 4'd2, 64'd3, 8'hFF, rd, re, lat);
      check("add_old", rd, 64'd5);
      req(32'hCAFE_0010, 1'b0, 4'd0, 64'd0, 8'hFF, rd, re, lat);
      check("add_new", rd, 64'd8);
      req(32'hCAFE_0010, 1'b0, 4'd6, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, re, lat);
      check("max_old", rd, 64'd8);
      req(32'hCAFE_0010, 1'b0, 4'd0, 64'd0, 8'hFF, rd, re, lat);
      check("max_new", rd, 64'd8);
      req(32'hCAFE_0010, 1'b0, 4'd7, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, re, lat);
      check("min_old", rd, 64'd8);
      req(32'hCAFE_0010, 1'b0, 4'd0, 64'd0, 8'hFF, rd, re, lat);
      check("min_new", rd, 64'hFFFF_FFFF_FFFF_FFFF);

      // Error requests must leave storage alone (word 0 catches truncated-index writes).
      req(32'hCAFE_0000, 1'b1, 4'd0, 64'd0, 8'hFF, rd, re, lat);
      for (int i = 0; i < 4; i++) begin
         req(e_addr[i], e_wr[i], e_amo[i], 64'h1234, 8'hFF, rd, re, lat);
         check($sformatf("err%0d_flag", i), 64'(re), 64'd1);
         check($sformatf("err%0d_data", i), rd, 64'd0);
      end
      req(32'hCAFE_0000, 1'b0, 4'd0, 64'd0, 8'hFF, rd, re, lat);
      check("err_w0_kept", rd, 64'd0);
      req(32'hCAFE_0010, 1'b0, 4'd0, 64'd0, 8'hFF, rd, re, lat);
      check("err_w2_kept", rd, 64'hFFFF_FFFF_FFFF_FFFF);

      // Back-to-back AMO ADD +1: responses must be 0,1,...,99 in order.
      req(32'hCAFE_0020, 1'b1, 4'd0, 64'd0, 8'hFF, rd, re, lat);
      qaddr = 32'hCAFE_0020; qwrite = 1'b0; qamo = 4'd2; qdata = 64'd1; qstrb = 8'hFF;
      got_n = 0; bad_ord = 0; stalls = 0;
      fork
         begin
            qvalid = 1'b1;
            for (int i = 0; i < 100; i++) begin
               if (!qready) stalls++;
               @(posedge clk); #1;
            end
            qvalid = 1'b0;
         end
         begin
            for (int c = 0; c < 300 && got_n < 100; c++) begin
               @(posedge clk); #1;
               if (pvalid) begin
                  if (pdata !== 64'(got_n) || perror) bad_ord++;
                  got_n++;
               end
            end
         end
      join
      @(posedge clk); #1;
      check("b2b_count", 64'(got_n), 64'd100);
      check("b2b_order", 64'(bad_ord), 64'd0);
      check("b2b_stalls", 64'(stalls), 64'd0);
      check("b2b_idle_pvalid", 64'(pvalid), 64'd0);
      req(32'hCAFE_0020, 1'b0, 4'd0, 64'd0, 8'hFF, rd, re, lat);
      check("b2b_final", rd, 64'd100);

      // Latency=3, MaxOutstanding=2 instance.
      qaddr2 = 32'hCAFE_0000; qwrite2 = 1'b1; qamo2 = 4'd0; qdata2 = 64'd10; qstrb2 = 8'hFF;
      qvalid2 = 1'b1;
      @(posedge clk); #1;
      qvalid2 = 1'b0;
      lat = 1;
      while (!pvalid2 && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      check("l3_lat", 64'(lat), 64'd3);
      @(posedge clk); #1;
      pready2 = 1'b0;
      qwrite2 = 1'b0; qamo2 = 4'd2; qdata2 = 64'd1;
      qvalid2 = 1'b1;
      acc = 0;
      repeat (6) begin
         if (qready2) acc++;
         @(posedge clk); #1;
      end
      qvalid2 = 1'b0;
      check("l3_accepted", 64'(acc), 64'd2);
      check("l3_qready_full", 64'(qready2), 64'd0);
      check("l3_pvalid_held", 64'(pvalid2), 64'd1);
      check("l3_pdata_held", pdata2, 64'd10);
      pready2 = 1'b1;
      k = 0;
      for (int c = 0; c < 10 && k < 2; c++) begin
         if (pvalid2) begin
            r[k] = pdata2;
            k++;
         end
         @(posedge clk); #1;
      end
      check("l3_resp_n", 64'(k), 64'd2);
      check("l3_resp0", r[0], 64'd10);
      check("l3_resp1", r[1], 64'd11);
      check("l3_qready_back", 64'(qready2), 64'd1);

      // Reset with three responses in flight; storage must survive.
      pready = 1'b0;
      qaddr = 32'hCAFE_1000; qwrite = 1'b0; qamo = 4'd0; qstrb = 8'hFF;
      qvalid = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      qvalid = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      check("rb_pvalid_before", 64'(pvalid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rb_pvalid", 64'(pvalid), 64'd0);
      check("rb_qready", 64'(qready), 64'd1);
      check("rb_pdata", pdata, 64'd0);
      @(negedge clk);
      rst_n  = 1'b1;
      pready = 1'b1;
      @(posedge clk); #1;
      req(32'hCAFE_1000, 1'b0, 4'd0, 64'd0, 8'hFF, rd, re, lat);
      check("rb_keep_1000", rd, 64'hAAAA_BBBB_0000_0001);
      req(32'hCAFE_0020, 1'b0, 4'd0, 64'd0, 8'hFF, rd, re, lat);
      check("rb_keep_0020", rd, 64'd100);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/snitch_data_mem.md
Name: snitch_data_mem

Overview:
- Parametrised data-memory responder for the snitch data request/response port (q-channel request, p-channel response).
- Generalises the fixed single-outstanding stub with:
  - real word storage and byte strobes
  - configurable response latency
  - bounded outstanding requests with credit-based qready
  - atomic memory operations
  - error responses
- Sits beside the core in benches and small integration tops.

Parameters:
- AddrWidth, 32, request address width.
- DataWidth, 64, data width; power of two, >= 32.
- NumWords, 1024, storage depth in DataWidth words.
- BaseAddr, 32'hCAFE_0000, byte address of word 0; aligned to DataWidth/8.
- Latency, 1, cycles from acceptance to earliest pvalid; >= 1.
- MaxOutstanding, 4, accepted-but-unacknowledged response limit; >= 1.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- data_qaddr_i  in  AddrWidth  request byte address.
- data_qwrite_i  in  1  1 = store, 0 = load or AMO.
- data_qamo_i  in  4  AMO opcode (package enum).
- data_qdata_i  in  DataWidth  store/AMO operand.
- data_qstrb_i  in  DataWidth/8  byte enables.
- data_qvalid_i  in  1  request valid.
- data_qready_o  out  1  request ready.
- data_pdata_o  out  DataWidth  response data.
- data_perror_o  out  1  response error.
- data_pvalid_o  out  1  response valid.
- data_pready_i  in  1  response ready.

Behaviour:
- Acceptance: a request is accepted when qvalid && qready. qready = (credit < MaxOutstanding), combinational from state only, never from qvalid.
- Credit counter:
  - +1 on acceptance, -1 on p handshake (pvalid && pready).
  - Both in the same cycle: unchanged.
  - Range 0..MaxOutstanding, never wraps.
- Address decode:
  - off = qaddr - BaseAddr (modular subtraction); idx = off >> log2(DataWidth/8); low offset bits ignored.
  - In range iff qaddr >= BaseAddr and idx < NumWords.
- Memory effect at the acceptance clock edge (a request accepted in the next cycle sees it):
  - Store: bytes with strb=1 written; response pdata=0, perror=0.
  - Load (qamo=AMO_NONE): response pdata = word before any update.
  - AMO (qwrite=0, qamo in SWAP/ADD/AND/OR/XOR/MAX/MIN): response pdata = old word. New word = op(old, qdata) computed on the full DataWidth (MAX/MIN signed), then written to strb-enabled bytes only.
- Errors: out-of-range address, or qwrite=1 with qamo != AMO_NONE, or undefined qamo value → no memory effect, pdata=0, perror=1. An error request still consumes a credit and returns a response.
- Pipeline:
  - Accepted result enters a Latency-stage delay line that advances every cycle, then an in-order response FIFO of depth MaxOutstanding.
  - FIFO cannot overflow: credits bound total occupancy.
  - Latency=1 with an empty FIFO gives pvalid in the cycle after acceptance.
  - Responses are strictly in acceptance order.
- Response stability: while pvalid && !pready, pdata and perror are held stable and pvalid stays 1.
- Back-to-back throughput: one request per cycle when pready is held high and MaxOutstanding >= Latency+1.
- Reset (async assert, sync deassert handled upstream):
  - credit=0, delay line invalid, FIFO empty.
  - pvalid_o=0, pdata_o=0, perror_o=0, qready_o=1 after reset.
  - In-flight requests are dropped.
  - Storage is not reset; contents persist across reset.
- Assertions:
  - qaddr/qwrite/qamo/qdata/qstrb stable while qvalid && !qready.
  - pvalid never 1 when credit=0.

Decomposition:
- Package snitch_mem_pkg:
  - amo_op_e (4-bit): NONE=0, SWAP=1, ADD=2, AND=3, OR=4, XOR=5, MAX=6, MIN=7; 8..15 undefined.
  - resp_t struct {data, error}.
  - function amo_apply(op, old, operand).
- Sub-module snitch_resp_fifo: parametrised in-order FIFO (Depth, resp_t) with push/pop/full/empty, instantiated for the response queue.

Test Plan:
- Latency=1: sw 0x0000_0000_0000_0001 @ 0xCAFE_1000 strb=0x0F, then load @ 0xCAFE_1000 → load response pdata=0x...0001, perror=0, pvalid exactly 1 cycle after acceptance.
- Latency=3, MaxOutstanding=2, pready=0: qvalid held → exactly 2 accepted, qready=0 afterwards. Raise pready → both responses return in order, then qready=1.
- AMO ADD: word=5, amo ADD operand 3 strb=0xFF → pdata=5; subsequent load → 8. AMO MAX with operand 0xFFFF_FFFF_FFFF_FFFF (-1) → word unchanged.
- Error cases, each → perror=1, pdata=0, memory unchanged:
  - address 0xCAFE_0000 + NumWords*8
  - address 0x0000_0000
  - qwrite=1 with qamo=SWAP
  - qamo=12
- Simultaneous: accept and p handshake in the same cycle for 100 cycles with pready=1 → credit constant, no dropped or duplicated responses (scoreboard).
- Assert rst_ni mid-burst with 3 outstanding → pvalid=0 and qready=1 immediately (async). Data written before reset is readable after reset.
